seven_segment_scanner: RTL
==========================

# seven_segment_scanner

Time-multiplexed scan driver for the 4-digit common-anode display on the board. It sits directly upstream of `seven_segment_decoder`. Each refresh slot, it selects one nibble of a 16-bit value and presents it on `hex` for the decoder. It also drives the matching active-low anode line and the decimal point. Features:
- Snapshots the displayed value once per frame, so digits never tear.
- Optional leading-zero blanking.
- A ghosting guard band between digit changes.

## Interface
Parameters:
- `REFRESH_DIV`, 100000: clock cycles per digit slot (1 kHz per digit at 100 MHz). Legal range 4..2^20.
- `GUARD`, 16: cycles at the start of each slot with all anodes off. Legal range 1..`REFRESH_DIV`-2.

Ports:
- `clk`, input, 1: system clock. One clock domain only.
- `rst_n`, input, 1: reset, asynchronous assert, active-low.
- `en`, input, 1: display enable. When low, all anodes are off and scanning continues.
- `value`, input, 16: four hex digits. Digit 0 is `value[3:0]` (rightmost); digit 3 is `value[15:12]`.
- `dp_in`, input, 4: decimal point request per digit, active-high.
- `lz_blank`, input, 1: leading-zero blanking enable.
- `hex`, output, 4: nibble for the current digit. Feeds `seven_segment_decoder.hex`.
- `an`, output, 4: anode enables, active-low, one-hot-low or all ones.
- `dp_n`, output, 1: decimal point cathode, active-low.
- `frame_start`, output, 1: single-cycle pulse when the snapshot is taken.

## Operation
- **Prescaler:** `div_cnt` counts 0..`REFRESH_DIV`-1 and wraps. `tick` is asserted when `div_cnt == REFRESH_DIV-1`.
- **Digit index:** `dig` is 2 bits and advances 0→1→2→3→0 on each `tick`. It wraps modulo 4.
- **Snapshot:** on a `tick` with `dig == 3`, the block captures:
  - `snap_val <= value`, `snap_dp <= dp_in`, `snap_lz <= lz_blank`.
  - `frame_start` pulses in the same cycle as the capture.
  - Every output derives from the snapshot only; nothing reads live inputs except `en`.
- **Blanking:** digit k ∈ {1,2,3} is blanked when `snap_lz` is set and `snap_val[15:4k]` is all zero. Digit 0 is never blanked.
- **Anode drive:** the selected anode goes low only when all of these hold:
  - `en` is high,
  - the digit is not blanked,
  - `div_cnt >= GUARD`.
  Otherwise `an = 4'b1111`.
- **Other outputs:** `hex = snap_val[4*dig +: 4]`. `dp_n = ~snap_dp[dig]`, forced to 1 whenever `an == 4'b1111`.
- **Registering:** all outputs are registered. There are no combinational paths from input to output.
- **Reset values:**
  - Outputs: `an = 4'b1111`, `hex = 4'h0`, `dp_n = 1`, `frame_start = 0`.
  - Internal state: `div_cnt = 0`, `dig = 0`, `snap_val = 16'h0000`, `snap_dp = 0`, `snap_lz = 0`.
- **Reset mid-frame:** all anodes turn off immediately (asynchronously). After release, scanning restarts at digit 0 with `snap_val = 0`. The first real snapshot occurs at the end of the first digit-3 slot.

## Timing
- `tick` occurs at cycle t. At t+1, `dig`, `hex` and `dp_n` show the new digit and `an = 1111`. The anode asserts at cycle t+1+`GUARD` and stays asserted through t+`REFRESH_DIV`.
- A change on `value` is displayed at the start of the next frame: latency is at most 4·`REFRESH_DIV`+1 cycles.
- When `en` falls, `an = 1111` from the next cycle. When `en` rises, the anode asserts from the next cycle if inside the active window, otherwise at the next window.
- If `lz_blank` or `dp_in` changes mid-frame, the change is ignored until the next snapshot.
- The first frame after reset is 4·`REFRESH_DIV` cycles. `frame_start` first pulses at cycle 4·`REFRESH_DIV`-1 after reset release.

## Structure
- **Shared package `seven_seg_pkg`:**
  - `NUM_DIGITS = 4`
  - `AN_OFF = 4'b1111`
  - typedef `digit_idx_t` (2-bit)
- **Sub-module `scan_tick_gen`:** the prescaler. Parameter `REFRESH_DIV`; outputs `tick` and `div_cnt`. It is reused by future scanned peripherals.
- **Top level:** instantiates `scan_tick_gen` and holds the digit counter, snapshot registers, blanking logic and output registers. `seven_segment_decoder` is instantiated by the parent, not inside this block.

## Test plan
Run with `REFRESH_DIV = 8`, `GUARD = 2`.
- **Reset:** hold `rst_n` low for 5 cycles, then release → `an = 1111`, `dp_n = 1`, `hex = 0` during reset. `frame_start` pulses first at cycle 31 after release.
- **Basic scan:** `value = 16'h1A3F`, `en = 1`, `lz_blank = 0` → in the second frame, `hex` sequences F, 3, A, 1. `an` sequences 1110, 1101, 1011, 0111, each active for 6 of 8 cycles with 2 off cycles first.
- **Leading-zero blanking:** `value = 16'h0050`, `lz_blank = 1` → digits 3 and 2 keep `an = 1111`; digit 1 shows 5; digit 0 shows 0. With `value = 16'h0000`, only digit 0 lights.
- **Tear-free update:** change `value` from `16'h1234` to `16'h5678` while digit 2 is active → the current frame completes as 4, 3, 2, 1. The next frame shows 8, 7, 6, 5.
- **Decimal point and enable:** `dp_in = 4'b0100` → `dp_n = 0` only while `an = 1011`. With `en` low for 3 cycles mid-slot → `an = 1111` and `dp_n = 1` from the next cycle. The anode resumes one cycle after `en` rises, and `dig` is unaffected.
- **Async reset mid-slot:** assert `rst_n` low while `an = 1101` → `an = 1111` with no clock edge. After release, the scan restarts at digit 0 showing 0.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - shared types, constants and helpers for the seven-segment scan driver
package seven_seg_pkg;

    localparam int NUM_DIGITS = 4;
    localparam logic [NUM_DIGITS-1:0] AN_OFF = 4'b1111;

    typedef logic [1:0] digit_idx_t;

    // A digit is a leading zero when it and every more-significant nibble are zero.
    function automatic logic digit_blanked(input logic [15:0] val, input logic lz, input digit_idx_t idx);
        logic zero_above;
        case (idx)
            2'd1:    zero_above = (val[15:4] == 12'h000);
            2'd2:    zero_above = (val[15:8] == 8'h00);
            2'd3:    zero_above = (val[15:12] == 4'h0);
            default: zero_above = 1'b0;
        endcase
        return lz && zero_above;
    endfunction

    function automatic logic [NUM_DIGITS-1:0] anode_sel(input digit_idx_t idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// rtl/scan_tick_gen.sv - free-running prescaler producing one tick per scan slot
module scan_tick_gen #(
    parameter int REFRESH_DIV = 100000,
    localparam int CW = $clog2(REFRESH_DIV)
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          tick,
    output logic [CW-1:0] div_cnt
);

    assign tick = (div_cnt == CW'(REFRESH_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/seven_segment_scanner.sv
// rtl/seven_segment_scanner.sv - 4-digit time-multiplexed scan driver with per-frame snapshot
module seven_segment_scanner
    import seven_seg_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD       = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic        lz_blank,
    output logic [3:0]  hex,
    output logic [3:0]  an,
    output logic        dp_n,
    output logic        frame_start
);

    localparam int CW = $clog2(REFRESH_DIV);

    logic          tick;
    logic [CW-1:0] div_cnt;
    digit_idx_t    dig;
    logic [15:0]   snap_val;
    logic [3:0]    snap_dp;
    logic          snap_lz;

    logic [CW-1:0] div_nxt;
    digit_idx_t    dig_nxt;
    logic          capture;
    logic [15:0]   val_nxt;
    logic [3:0]    dpv_nxt;
    logic          lz_nxt;
    logic          lit;
    logic [3:0]    an_nxt;
    logic [3:0]    hex_nxt;
    logic          dp_n_nxt;
    logic          fs_nxt;

    scan_tick_gen #(
        .REFRESH_DIV(REFRESH_DIV)
    ) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick   (tick),
        .div_cnt(div_cnt)
    );

    // Output registers are loaded from next-state values so they line up with
    // the slot they describe rather than lagging it by a cycle.
    always_comb begin
        div_nxt  = tick ? '0 : div_cnt + CW'(1);
        dig_nxt  = tick ? dig + 2'd1 : dig;
        capture  = tick && (dig == 2'd3);
        val_nxt  = capture ? value    : snap_val;
        dpv_nxt  = capture ? dp_in    : snap_dp;
        lz_nxt   = capture ? lz_blank : snap_lz;
        lit      = en && !digit_blanked(val_nxt, lz_nxt, dig_nxt) && (div_nxt >= CW'(GUARD));
        an_nxt   = lit ? anode_sel(dig_nxt) : AN_OFF;
        dp_n_nxt = lit ? ~dpv_nxt[dig_nxt] : 1'b1;
        hex_nxt  = val_nxt[{dig_nxt, 2'b00} +: 4];
        fs_nxt   = (div_nxt == CW'(REFRESH_DIV - 1)) && (dig_nxt == 2'd3);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dig         <= 2'd0;
            snap_val    <= 16'h0000;
            snap_dp     <= 4'b0000;
            snap_lz     <= 1'b0;
            an          <= AN_OFF;
            hex         <= 4'h0;
            dp_n        <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            dig         <= dig_nxt;
            snap_val    <= val_nxt;
            snap_dp     <= dpv_nxt;
            snap_lz     <= lz_nxt;
            an          <= an_nxt;
            hex         <= hex_nxt;
            dp_n        <= dp_n_nxt;
            frame_start <= fs_nxt;
        end
    end

endmodule
